// File: rtl/booth_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module      : booth_seq_mult
//  Description : Sequential radix-2 Booth multiplier for signed two's-complement
//                operands. One Booth iteration per clock, with a start/done
//                handshake. The product is read directly from the A/Q registers.
//  Revision    : 1.0  initial release
// ============================================================================
module booth_seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Iteration counter width; it must be able to hold the value WIDTH.
    localparam int C_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state_q, w_state_d;
    // M and A carry one extra bit so that -M is representable when the
    // multiplicand is the most negative value.
    logic [WIDTH:0]       r_m_q, w_m_d;
    logic [WIDTH:0]       r_a_q, w_a_d;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     r_q_q, w_q_d;
    logic                 r_q1_q, w_q1_d;
    logic [C_CNT_W-1:0]   r_cnt_q, w_cnt_d;
    logic                 r_busy_q, w_busy_d;
    logic                 r_done_q, w_done_d;

    // Booth recoding: {Q[0], q_1} picks subtract, add or pass-through of M.
    always_comb begin
        case ({r_q_q[0], r_q1_q})
            2'b10:   w_sum = r_a_q - r_m_q;
            2'b01:   w_sum = r_a_q + r_m_q;
            default: w_sum = r_a_q;
        endcase
    end

    // Next-state and datapath update for load, iterate and done phases.
    always_comb begin
        w_state_d = r_state_q;
        w_m_d     = r_m_q;
        w_a_d     = r_a_q;
        w_q_d     = r_q_q;
        w_q1_d    = r_q1_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_m_d     = {multiplicand[WIDTH-1], multiplicand};
                    w_a_d     = '0;
                    w_q_d     = multiplier;
                    w_q1_d    = 1'b0;
                    w_cnt_d   = C_CNT_W'(WIDTH);
                    w_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Arithmetic right shift of {S, Q, q_1}, sign of S replicated.
                w_a_d   = {w_sum[WIDTH], w_sum[WIDTH:1]};
                w_q_d   = {w_sum[0], r_q_q[WIDTH-1:1]};
                w_q1_d  = r_q_q[0];
                w_cnt_d = r_cnt_q - C_CNT_W'(1);
                if (r_cnt_q == C_CNT_W'(1)) begin
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
        // Status outputs are registered, so derive them from the next state.
        w_busy_d = (w_state_d != ST_IDLE);
        w_done_d = (w_state_d == ST_DONE);
    end

    // State and datapath registers; reset clears everything, even mid-run.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_m_q     <= '0;
            r_a_q     <= '0;
            r_q_q     <= '0;
            r_q1_q    <= 1'b0;
            r_cnt_q   <= '0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_m_q     <= w_m_d;
            r_a_q     <= w_a_d;
            r_q_q     <= w_q_d;
            r_q1_q    <= w_q1_d;
            r_cnt_q   <= w_cnt_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign busy    = r_busy_q;
    assign done    = r_done_q;
    assign product = {r_a_q[WIDTH-1:0], r_q_q};

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_seq_mult
//  Description : Self-checking bench for booth_seq_mult at WIDTH=4 and WIDTH=8
//                against an integer-multiply reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_booth_seq_mult;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, st4, busy4, done4;
    logic [3:0]  mc4, mp4;
    logic [7:0]  p4;
    logic        rst8, st8, busy8, done8;
    logic [7:0]  mc8, mp8;
    logic [15:0] p8;

    int n_vec = 0;
    int n_err = 0;

    booth_seq_mult #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(rst4), .start(st4),
        .multiplicand(mc4), .multiplier(mp4),
        .busy(busy4), .done(done4), .product(p4)
    );

    booth_seq_mult #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(rst8), .start(st8),
        .multiplicand(mc8), .multiplier(mp8),
        .busy(busy8), .done(done8), .product(p8)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed integer multiply, truncated to product width.
    function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b);
        int x, y;
        x = $signed(a);
        y = $signed(b);
        return 8'(x * y);
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
        int x, y;
        x = $signed(a);
        y = $signed(b);
        return 16'(x * y);
    endfunction

    task automatic mul4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp, input string tag);
        int lat;
        @(negedge clk);
        mc4 = a; mp4 = b; st4 = 1'b1;
        @(negedge clk);
        st4 = 1'b0; mc4 = 4'($urandom); mp4 = 4'($urandom);
        check_eq({tag, " busy"}, 32'(busy4), 32'd1);
        lat = 0;
        while (done4 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, " latency"}, lat, 32'd4);
        check_eq({tag, " product"}, 32'(p4), 32'(exp));
        @(negedge clk);
        check_eq({tag, " idle"}, 32'({busy4, done4}), 32'd0);
        check_eq({tag, " hold"}, 32'(p4), 32'(exp));
    endtask

    task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input string tag);
        int lat;
        @(negedge clk);
        mc8 = a; mp8 = b; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0; mc8 = 8'($urandom); mp8 = 8'($urandom);
        lat = 0;
        while (done8 !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, " latency"}, lat, 32'd8);
        check_eq({tag, " product"}, 32'(p8), 32'(exp));
        @(negedge clk);
        check_eq({tag, " idle"}, 32'({busy8, done8}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dk, seen, waitc;
        int dq[$];
        logic [7:0] ra, rb;

        rst4 = 1'b1; rst8 = 1'b1; st4 = 1'b0; st8 = 1'b0;
        mc4 = '0; mp4 = '0; mc8 = '0; mp8 = '0;
        repeat (3) @(negedge clk);
        check_eq("reset4", 32'({busy4, done4, p4}), 32'd0);
        check_eq("reset8", 32'({busy8, done8, p8}), 32'd0);
        rst4 = 1'b0; rst8 = 1'b0;

        // Directed cases with hand-computed products.
        mul4(4'd3, 4'hE, 8'hFA, "3x-2");
        mul4(4'h8, 4'h8, 8'h40, "-8x-8");
        mul4(4'h8, 4'h7, 8'hC8, "-8x7");
        mul4(4'h7, 4'h7, 8'h31, "7x7");
        mul4(4'h0, 4'hB, 8'h00, "0x-5");
        mul8(8'h80, 8'h80, 16'h4000, "-128x-128");
        mul8(8'h7F, 8'h80, 16'hC080, "127x-128");

        // Exhaustive WIDTH=4 sweep against the model.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                mul4(4'(i), 4'(j), ref4(4'(i), 4'(j)), "sweep4");
            end
        end

        // Random WIDTH=8 operands against the model.
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            mul8(ra, rb, ref8(ra, rb), "rand8");
        end

        // Start pulses during RUN and DONE must be ignored.
        @(negedge clk);
        mc4 = 4'd3; mp4 = 4'd3; st4 = 1'b1;
        @(negedge clk);
        mc4 = 4'd5; mp4 = 4'd5;
        dk = -1;
        for (int k = 0; k < 10; k++) begin
            st4 = (k == 1 || k == 4);
            if (done4 === 1'b1) begin
                if (dk < 0) dk = k;
                check_eq("ignore done product", 32'(p4), 32'h09);
            end
            if (k >= 5) begin
                check_eq("ignore idle busy", 32'(busy4), 32'd0);
                check_eq("ignore idle product", 32'(p4), 32'h09);
            end
            @(negedge clk);
        end
        st4 = 1'b0;
        check_eq("ignore done cycle", dk, 32'd4);

        // Reset during RUN aborts with no done pulse.
        @(negedge clk);
        mc4 = 4'd6; mp4 = 4'd5; st4 = 1'b1;
        @(negedge clk);
        st4 = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        check_eq("abort busy", 32'(busy4), 32'd0);
        check_eq("abort done", 32'(done4), 32'd0);
        check_eq("abort product", 32'(p4), 32'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done4 === 1'b1) seen++;
        end
        check_eq("abort no done", seen, 32'd0);
        mul4(4'd2, 4'd3, 8'h06, "2x3 after abort");

        // Start held high: one multiply every WIDTH+2 cycles.
        @(negedge clk);
        mc4 = 4'd1; mp4 = 4'hF; st4 = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done4 === 1'b1) begin
                dq.push_back(k);
                check_eq("b2b product", 32'(p4), 32'hFF);
            end
        end
        st4 = 1'b0;
        check_eq("b2b pulses", dq.size(), 32'd6);
        if (dq.size() > 0) check_eq("b2b first", dq[0], 32'd4);
        for (int i = 1; i < dq.size(); i++) begin
            check_eq("b2b period", dq[i] - dq[i-1], 32'd6);
        end
        waitc = 0;
        while (busy4 !== 1'b0 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check_eq("b2b drain", 32'(busy4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
